baud_tick_sched: RTL

//  Run-time scheduler for satcom serial timing. Derives a 16x oversample enable
//  (ovs_tick) and a 1200 b/s bit enable (bit_tick) from master_clk.

---
 rtl/baud_tick_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/baud_tick_sched.sv
// Oversample/bit tick scheduler: single-cycle enables in the master_clk domain,
// with divisor changes deferred to bit boundaries and start-bit phase resync.
module baud_tick_sched #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned OVS         = 16,
    parameter int unsigned DEFAULT_DIV = 5208
) (
    input  logic                    master_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    resync,
    output logic                    ovs_tick,
    output logic                    bit_tick,
    output logic [$clog2(OVS)-1:0]  ovs_phase,
    output logic                    running,
    output logic [DIV_W-1:0]        div_active
);

    localparam int unsigned     PH_W    = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVS / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  pend_q, pend_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              ovs_tick_q, ovs_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              ready_q, ready_d;
    logic              running_q, running_d;

    logic              cfg_acc;
    logic              terminal;
    logic [DIV_W-1:0]  cfg_clamped;

    assign cfg_acc     = cfg_valid & ready_q;
    assign cfg_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign terminal    = (cnt_q == (div_q - DIV_W'(1)));

    // State and output registers
    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            pend_q     <= DIV_W'(DEFAULT_DIV);
            phase_q    <= '0;
            ovs_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            ready_q    <= 1'b1;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            phase_q    <= phase_d;
            ovs_tick_q <= ovs_tick_d;
            bit_tick_q <= bit_tick_d;
            ready_q    <= ready_d;
            running_q  <= running_d;
        end
    end

    // Next-state and tick generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        ovs_tick_d = 1'b0;
        bit_tick_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                phase_d = '0;
                if (cfg_acc) div_d = cfg_clamped;
                if (enable)  state_d = ST_RUN;
            end
            ST_RUN, ST_PEND: begin
                if (!enable) begin
                    // Stopping flushes any deferred divisor straight into use
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    phase_d = '0;
                    if (state_q == ST_PEND) div_d = pend_q;
                    else if (cfg_acc)       div_d = cfg_clamped;
                end else begin
                    if (resync) begin
                        cnt_d   = '0;
                        phase_d = PH_HALF;
                        if (state_q == ST_PEND) begin
                            div_d   = pend_q;
                            state_d = ST_RUN;
                        end
                    end else if (terminal) begin
                        cnt_d      = '0;
                        ovs_tick_d = 1'b1;
                        phase_d    = phase_q + PH_W'(1);
                        if (phase_q == PH_LAST) begin
                            bit_tick_d = 1'b1;
                            if (state_q == ST_PEND) begin
                                div_d   = pend_q;
                                state_d = ST_RUN;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    if ((state_q == ST_RUN) && cfg_acc) begin
                        pend_d  = cfg_clamped;
                        state_d = ST_PEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d   = (state_d != ST_PEND);
        running_d = (state_d != ST_IDLE);
    end

    assign cfg_ready  = ready_q;
    assign ovs_tick   = ovs_tick_q;
    assign bit_tick   = bit_tick_q;
    assign ovs_phase  = phase_q;
    assign running    = running_q;
    assign div_active = div_q;

endmodule
